ps2_data_output: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED/typematic commands) from the controller to the keyboard over the open-drain PS/2 clock/data lines. Inhibits the bus, issues the request-to-send, shifts out 8 data bits LSB-first plus odd parity and stop on device-generated clock edges, then checks the device acknowledge. It is the counterpart of the PS/2 receiver and shares its synchronised edge strobes (`ps2_clk_posedge`/`ps2_clk_negedge`).

---
 rtl/ps2_data_output.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_data_output.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_data_output.sv
// ---------------------------------------------------------------------------
// ps2_data_output
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the open-drain PS/2 clock/data lines. The sequence is:
//   1. inhibit the bus by holding the clock low,
//   2. issue the request-to-send by also pulling data low (start bit),
//   3. release the clock and shift out 8 data bits LSB-first, odd parity
//      and the stop bit on device-generated falling clock edges,
//   4. sample the device acknowledge and report done or error.
// A watchdog aborts the transfer if the device stops clocking.
//
// Parameters
//   CLK_HOLD_CYCLES  clock-inhibit length in clk cycles
//   TIMEOUT_CYCLES   maximum clk cycles between device clock edges
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   ps2_tx_data      byte to send, sampled on an accepted start
//   ps2_tx_start     one-cycle request, ignored while busy
//   ps2_clk_posedge  one-cycle strobe, synchronised PS/2 clock rising edge
//   ps2_clk_negedge  one-cycle strobe, synchronised PS/2 clock falling edge
//   ps2_data         synchronised PS/2 data line level
//   ps2_clk_oe       1 = pull PS/2 clock low
//   ps2_data_oe      1 = pull PS/2 data low
//   ps2_tx_busy      transfer in progress
//   ps2_tx_done      one-cycle strobe, byte sent and acknowledged
//   ps2_tx_error     one-cycle strobe, missing acknowledge or timeout
// ---------------------------------------------------------------------------
module ps2_data_output #(
  parameter int CLK_HOLD_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES  = 150000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_tx_data,
  input  logic       ps2_tx_start,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       ps2_tx_busy,
  output logic       ps2_tx_done,
  output logic       ps2_tx_error
);

  // One counter serves both the clock-inhibit interval and the edge watchdog.
  localparam int CNT_MAX = (CLK_HOLD_CYCLES > TIMEOUT_CYCLES) ? CLK_HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CLK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLK_HOLD = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_CLK = 3'd3,
    S_SEND     = 3'd4,
    S_ACK      = 3'd5,
    S_ACK_WAIT = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [7:0]       r_shift;
  logic             r_parity;
  logic [3:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack_ok;

  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_accept;
  logic             w_edge;
  logic             w_watch;
  logic             w_timeout;
  logic             w_finish;

  logic             w_clk_oe_nxt;
  logic             w_data_oe_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  // A start landing on the done/error cycle is dropped so the caller always
  // sees the end of one transfer before the next one begins.
  assign w_accept  = (r_state == S_IDLE) && ps2_tx_start && !r_done && !r_error;
  assign w_edge    = ps2_clk_posedge | ps2_clk_negedge;
  assign w_watch   = (r_state == S_WAIT_CLK) || (r_state == S_SEND) ||
                     (r_state == S_ACK)      || (r_state == S_ACK_WAIT);
  assign w_timeout = w_watch && !w_edge && (r_cnt == TIMEOUT_LAST);
  assign w_finish  = (r_state == S_ACK_WAIT) && ps2_clk_posedge;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next_state = S_CLK_HOLD;
      S_CLK_HOLD: if (r_cnt == HOLD_LAST) w_next_state = S_REQ;
      S_REQ:      w_next_state = S_WAIT_CLK;
      S_WAIT_CLK: begin
        if (w_timeout)            w_next_state = S_IDLE;
        else if (ps2_clk_negedge) w_next_state = S_SEND;
      end
      S_SEND: begin
        if (w_timeout)                                   w_next_state = S_IDLE;
        else if (ps2_clk_negedge && (r_bit_cnt == 4'd9)) w_next_state = S_ACK;
      end
      S_ACK: begin
        if (w_timeout)            w_next_state = S_IDLE;
        else if (ps2_clk_negedge) w_next_state = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (w_timeout)            w_next_state = S_IDLE;
        else if (ps2_clk_posedge) w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_clk_oe_nxt  = (w_next_state == S_CLK_HOLD) || (w_next_state == S_REQ);
    w_busy_nxt    = (w_next_state != S_IDLE);
    w_done_nxt    = w_finish && r_ack_ok;
    w_error_nxt   = (w_finish && !r_ack_ok) || w_timeout;

    w_data_oe_nxt = r_data_oe;
    case (r_state)
      S_CLK_HOLD: w_data_oe_nxt = (w_next_state == S_REQ);
      S_REQ:      w_data_oe_nxt = 1'b1;
      // Start bit stays driven until the first falling edge.
      S_WAIT_CLK: if (ps2_clk_negedge) w_data_oe_nxt = ~r_shift[0];
      S_SEND: begin
        if (ps2_clk_negedge) begin
          if (r_bit_cnt == 4'd9)      w_data_oe_nxt = 1'b0;       // stop bit: release
          else if (r_bit_cnt == 4'd8) w_data_oe_nxt = ~r_parity;
          else                        w_data_oe_nxt = ~r_shift[r_bit_cnt[2:0]];
        end
      end
      default:    w_data_oe_nxt = 1'b0;
    endcase
    // Any return to IDLE (timeout included) releases the data line.
    if (w_next_state == S_IDLE) w_data_oe_nxt = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Datapath: shift register, parity, bit counter, hold/timeout counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_ack_ok  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= ps2_tx_data;
            r_parity  <= ~^ps2_tx_data;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_ack_ok  <= 1'b0;
          end
        end
        S_CLK_HOLD: r_cnt <= (r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
        S_REQ:      r_cnt <= '0;
        S_WAIT_CLK, S_SEND, S_ACK, S_ACK_WAIT: begin
          // Watchdog restarts on every device clock edge.
          r_cnt <= (w_edge || w_timeout) ? '0 : r_cnt + 1'b1;
          if (ps2_clk_negedge) begin
            if (r_state == S_WAIT_CLK) r_bit_cnt <= 4'd1;
            if (r_state == S_SEND)     r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == S_ACK)      r_ack_ok  <= ~ps2_data;
          end
        end
        default:    r_cnt <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  assign ps2_clk_oe   = r_clk_oe;
  assign ps2_data_oe  = r_data_oe;
  assign ps2_tx_busy  = r_busy;
  assign ps2_tx_done  = r_done;
  assign ps2_tx_error = r_error;

endmodule

// File: tb/tb_ps2_data_output.sv
// ---------------------------------------------------------------------------
// tb_ps2_data_output
//
// Testbench for ps2_data_output. A keyboard model answers the
// request-to-send by generating PS/2 clock strobes, reconstructs the byte
// from the data line, and optionally acknowledges. Expected outcomes are
// queued when each transfer is issued; a monitor pops them whenever the DUT
// pulses done or error.
// ---------------------------------------------------------------------------
module tb_ps2_data_output;

  localparam int H = 1200;   // clock-inhibit cycles
  localparam int T = 3000;   // watchdog cycles (shortened for simulation time)

  typedef enum int {DEV_ACK, DEV_NOACK, DEV_SILENT, DEV_RST5} dev_mode_t;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    bit         has_rx;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         parity_ok;
    bit         stop_ok;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_tx_data = 8'h00;
  logic       ps2_tx_start = 1'b0;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       ps2_tx_busy;
  logic       ps2_tx_done;
  logic       ps2_tx_error;

  logic       dev_pull = 1'b0;   // keyboard pulling data low (acknowledge)

  // Open-drain data line seen by both sides.
  assign ps2_data = ~(ps2_data_oe | dev_pull);

  ps2_data_output #(
    .CLK_HOLD_CYCLES(H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_tx_data    (ps2_tx_data),
    .ps2_tx_start   (ps2_tx_start),
    .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_clk_negedge(ps2_clk_negedge),
    .ps2_data       (ps2_data),
    .ps2_clk_oe     (ps2_clk_oe),
    .ps2_data_oe    (ps2_data_oe),
    .ps2_tx_busy    (ps2_tx_busy),
    .ps2_tx_done    (ps2_tx_done),
    .ps2_tx_error   (ps2_tx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  rx_t  rx_q[$];

  dev_mode_t  dev_mode = DEV_ACK;
  int         dev_hp = 10;
  int         dev_negs = 0;
  bit         dev_hit5 = 1'b0;
  logic [9:0] oe_seq = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Keyboard model
  // -------------------------------------------------------------------------
  task automatic dev_half();
    repeat (dev_hp) @(negedge clk);
  endtask

  task automatic dev_clock();
    logic [9:0] line;
    rx_t        r;
    line     = '0;
    dev_negs = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && dev_mode == DEV_ACK) dev_pull = 1'b1;
      dev_half();
      ps2_clk_negedge = 1'b1;
      @(negedge clk);
      ps2_clk_negedge = 1'b0;
      dev_negs++;
      if (dev_mode == DEV_RST5 && dev_negs == 5) begin
        dev_hit5 = 1'b1;
        return;
      end
      dev_half();
      if (i < 10) begin
        line[i]   = ps2_data;
        oe_seq[i] = ps2_data_oe;
      end
      ps2_clk_posedge = 1'b1;
      @(negedge clk);
      ps2_clk_posedge = 1'b0;
      if (i == 9) begin
        r.data      = line[7:0];
        r.parity_ok = ^line[8:0];     // odd number of ones over data + parity
        r.stop_ok   = line[9];
        rx_q.push_back(r);
      end
    end
    dev_pull = 1'b0;
  endtask

  initial begin : keyboard
    int hold_len;
    int req_len;
    hold_len = 0;
    req_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_len = 0;
        req_len  = 0;
      end else if (ps2_clk_oe) begin
        hold_len++;
        if (ps2_data_oe) req_len++;
      end else if (hold_len != 0) begin
        // Clock released after the inhibit: request-to-send seen.
        check("hold_len", hold_len, H + 1);
        check("req_len", req_len, 1);
        check("start_bit_oe", ps2_data_oe, 1);
        hold_len = 0;
        req_len  = 0;
        if (dev_mode != DEV_SILENT) dev_clock();
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard monitor
  // -------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    rx_t  r;
    forever begin
      @(negedge clk);
      if (rst_n && (ps2_tx_done || ps2_tx_error)) begin
        check("done_error_exclusive", ps2_tx_done & ps2_tx_error, 0);
        check("busy_at_end", ps2_tx_busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_end: done=%0b error=%0b with no transfer outstanding",
                   ps2_tx_done, ps2_tx_error);
        end else begin
          e = exp_q.pop_front();
          check("done", ps2_tx_done, e.ok);
          check("error", ps2_tx_error, !e.ok);
          if (e.has_rx) begin
            if (rx_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rx_missing: no byte reached the keyboard, expected 0x%02h", e.data);
            end else begin
              r = rx_q.pop_front();
              check("rx_byte", r.data, e.data);
              check("rx_parity_odd", r.parity_ok, 1);
              check("rx_stop", r.stop_ok, 1);
            end
          end
        end
        @(negedge clk);
        check("pulse_width", {ps2_tx_done, ps2_tx_error}, 0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic send(input logic [7:0] d, input dev_mode_t m);
    exp_t e;
    dev_mode     = m;
    dev_hp       = int'($urandom_range(4, 30));
    ps2_tx_data  = d;
    ps2_tx_start = 1'b1;
    if (m != DEV_RST5) begin
      e.data   = d;
      e.ok     = (m == DEV_ACK);
      e.has_rx = (m == DEV_ACK) || (m == DEV_NOACK);
      exp_q.push_back(e);
    end
    @(negedge clk);
    ps2_tx_start = 1'b0;
    ps2_tx_data  = 8'($urandom);
    check("busy_after_start", ps2_tx_busy, 1);
    check("clk_oe_after_start", ps2_clk_oe, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ps2_tx_busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, ps2_tx_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_clk_release();
    int n;
    n = 0;
    while (ps2_clk_oe && n < H + 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", ps2_tx_busy, 0);
    check("rst_done", ps2_tx_done, 0);
    check("rst_error", ps2_tx_error, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LED command with acknowledge, bit-level line sequence checked.
    send(8'hED, DEV_ACK);
    wait_idle("idle_ed");
    check("ed_oe_seq", oe_seq, 10'h012);

    send(8'hF4, DEV_ACK);
    wait_idle("idle_f4");
    send(8'h00, DEV_ACK);
    wait_idle("idle_00");

    // Keyboard never acknowledges.
    send(8'hA7, DEV_NOACK);
    wait_idle("idle_noack");

    // Keyboard never clocks: watchdog error.
    send(8'h3C, DEV_SILENT);
    wait_clk_release();
    check("to_clk_released", ps2_clk_oe, 0);
    check("to_start_bit", ps2_data_oe, 1);
    n = 0;
    while (!ps2_tx_error && n < T + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, T);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("to_lines_after", {ps2_clk_oe, ps2_data_oe}, 0);
    wait_idle("idle_timeout");

    // Start pulsed mid-transfer must be ignored.
    send(8'hC3, DEV_ACK);
    wait_clk_release();
    @(negedge clk);
    n = 0;
    while (dev_negs < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("collide_in_send", ps2_tx_busy, 1);
    ps2_tx_data  = 8'h55;
    ps2_tx_start = 1'b1;
    @(negedge clk);
    ps2_tx_start = 1'b0;
    wait_idle("idle_collide");
    send(8'h55, DEV_ACK);
    wait_idle("idle_55");

    // Reset asserted at the 5th falling edge.
    send(8'hA5, DEV_RST5);
    n = 0;
    while (!dev_hit5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rst5_reached", dev_hit5, 1);
    check("rst5_busy", ps2_tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst5_outputs", {ps2_clk_oe, ps2_data_oe, ps2_tx_busy, ps2_tx_done, ps2_tx_error}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hFF, DEV_ACK);
    wait_idle("idle_ff");

    // Random bytes, occasionally without acknowledge.
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? DEV_NOACK : DEV_ACK);
      wait_idle("idle_random");
    end

    repeat (5) @(negedge clk);
    check("sb_exp_empty", exp_q.size(), 0);
    check("sb_rx_empty", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
